// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared INTCON bit map, interrupt FSM states, source codes and register addresses
package pic_pkg;

  localparam int GIE_BIT    = 7;
  localparam int PEIE_BIT   = 6;
  localparam int TMR0IE_BIT = 5;
  localparam int INTE_BIT   = 4;
  localparam int IOCIE_BIT  = 3;
  localparam int TMR0IF_BIT = 2;
  localparam int INTF_BIT   = 1;
  localparam int IOCIF_BIT  = 0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PUSH,
    SAVE,
    VEC,
    ISR
  } irqState_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_INT  = 2'd1;
  localparam logic [1:0] SRC_TMR0 = 2'd2;
  localparam logic [1:0] SRC_IOC  = 2'd3;

  localparam logic [6:0] INTCON_ADDR   = 7'h0B;
  localparam logic [6:0] SHADOW_W_ADDR = 7'h09;

  // Highest-priority enabled-and-flagged source: INT, then TMR0, then IOC.
  function automatic logic [1:0] pickSrc(input logic [7:0] intcon);
    if (intcon[INTE_BIT] && intcon[INTF_BIT])
      pickSrc = SRC_INT;
    else if (intcon[TMR0IE_BIT] && intcon[TMR0IF_BIT])
      pickSrc = SRC_TMR0;
    else if (intcon[IOCIE_BIT] && intcon[IOCIF_BIT])
      pickSrc = SRC_IOC;
    else
      pickSrc = SRC_NONE;
  endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - rising-edge detector with an optional 2-flop input synchronizer
// SYNC_EN is driven from the INT_SYNC_EN build macro by the top level.
module edge_det #(
  parameter bit SYNC_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sampled;
  logic prevQ;

  generate
    if (SYNC_EN) begin : gSync
      logic metaQ;
      logic stableQ;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          metaQ   <= 1'b0;
          stableQ <= 1'b0;
        end else begin
          metaQ   <= d;
          stableQ <= metaQ;
        end
      end
      assign sampled = stableQ;
    end else begin : gDirect
      assign sampled = d;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prevQ <= 1'b0;
    else     prevQ <= sampled;
  end

  assign rise = sampled & ~prevQ;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - INTCON owner and interrupt-entry sequencer for the PIC16F1826 core
// Build macro INT_SYNC_EN: synchronize int_in and ioc_in before edge detection.
module int_ctrl
  import pic_pkg::*;
#(
  parameter int              PC_W   = 11,
  parameter logic [PC_W-1:0] VECTOR = 11'h004
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_in,
  input  logic            ioc_in,
  input  logic            tmr0_ovf,
  input  logic            intcon_we,
  input  logic [7:0]      intcon_wdata,
  output logic [7:0]      intcon_q,
  output logic            irq_req,
  input  logic            irq_ack,
  input  logic            retfie,
  output logic            push_pc,
  output logic            save_w,
  output logic            vec_load,
  output logic [PC_W-1:0] vec_addr,
  output logic [1:0]      irq_src,
  output logic            in_isr
);

`ifdef INT_SYNC_EN
  localparam bit SYNC_PINS = 1'b1;
`else
  localparam bit SYNC_PINS = 1'b0;
`endif

  logic       intRise;
  logic       iocRise;
  logic       tmrRise;
  logic [7:0] intconQ;
  logic [7:0] intconNext;
  logic [7:0] hwSet;
  logic       pend;
  logic       ackTaken;
  irqState_t  state;

  edge_det #(.SYNC_EN(SYNC_PINS)) uIntEdge (
    .clk (clk),
    .rst (rst),
    .d   (int_in),
    .rise(intRise)
  );

  edge_det #(.SYNC_EN(SYNC_PINS)) uIocEdge (
    .clk (clk),
    .rst (rst),
    .d   (ioc_in),
    .rise(iocRise)
  );

  // Timer0 overflow is already in the core clock domain.
  edge_det #(.SYNC_EN(1'b0)) uTmrEdge (
    .clk (clk),
    .rst (rst),
    .d   (tmr0_ovf),
    .rise(tmrRise)
  );

  assign pend = |({intconQ[TMR0IE_BIT], intconQ[INTE_BIT], intconQ[IOCIE_BIT]} &
                  {intconQ[TMR0IF_BIT], intconQ[INTF_BIT], intconQ[IOCIF_BIT]});

  assign ackTaken = (state == REQ) && irq_ack;

  // Hardware flag sets are OR-ed on top of a core write so an edge is never lost.
  always_comb begin
    hwSet             = 8'h00;
    hwSet[INTF_BIT]   = intRise;
    hwSet[IOCIF_BIT]  = iocRise;
    hwSet[TMR0IF_BIT] = tmrRise;
    intconNext        = intcon_we ? intcon_wdata : intconQ;
    intconNext        = intconNext | hwSet;
    if (retfie)   intconNext[GIE_BIT] = 1'b1;
    if (ackTaken) intconNext[GIE_BIT] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) intconQ <= 8'h00;
    else     intconQ <= intconNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      irq_req  <= 1'b0;
      push_pc  <= 1'b0;
      save_w   <= 1'b0;
      vec_load <= 1'b0;
      in_isr   <= 1'b0;
      irq_src  <= SRC_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (intconQ[GIE_BIT] && pend) begin
            state   <= REQ;
            irq_req <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= PUSH;
            irq_req <= 1'b0;
            push_pc <= 1'b1;
            irq_src <= pickSrc(intconQ);
          end else if (!(intconQ[GIE_BIT] && pend)) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        PUSH: begin
          state   <= SAVE;
          push_pc <= 1'b0;
          save_w  <= 1'b1;
        end
        SAVE: begin
          state    <= VEC;
          save_w   <= 1'b0;
          vec_load <= 1'b1;
        end
        VEC: begin
          state    <= ISR;
          vec_load <= 1'b0;
          in_isr   <= 1'b1;
        end
        ISR: begin
          if (retfie) begin
            state   <= IDLE;
            in_isr  <= 1'b0;
            irq_src <= SRC_NONE;
          end
        end
        default: begin
          state    <= IDLE;
          irq_req  <= 1'b0;
          push_pc  <= 1'b0;
          save_w   <= 1'b0;
          vec_load <= 1'b0;
          in_isr   <= 1'b0;
          irq_src  <= SRC_NONE;
        end
      endcase
    end
  end

  assign intcon_q = intconQ;
  assign vec_addr = VECTOR;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl (default build, INT_SYNC_EN undefined)
module tb_int_ctrl;

  logic        clk;
  logic        rst;
  logic        int_in;
  logic        ioc_in;
  logic        tmr0_ovf;
  logic        intcon_we;
  logic [7:0]  intcon_wdata;
  logic [7:0]  intcon_q;
  logic        irq_req;
  logic        irq_ack;
  logic        retfie;
  logic        push_pc;
  logic        save_w;
  logic        vec_load;
  logic [10:0] vec_addr;
  logic [1:0]  irq_src;
  logic        in_isr;

  int total = 0;
  int bad   = 0;

  int_ctrl #(.PC_W(11), .VECTOR(11'h004)) dut (
    .clk         (clk),
    .rst         (rst),
    .int_in      (int_in),
    .ioc_in      (ioc_in),
    .tmr0_ovf    (tmr0_ovf),
    .intcon_we   (intcon_we),
    .intcon_wdata(intcon_wdata),
    .intcon_q    (intcon_q),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack),
    .retfie      (retfie),
    .push_pc     (push_pc),
    .save_w      (save_w),
    .vec_load    (vec_load),
    .vec_addr    (vec_addr),
    .irq_src     (irq_src),
    .in_isr      (in_isr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wrIntcon(input logic [7:0] v);
    intcon_we    = 1'b1;
    intcon_wdata = v;
    cycle(1);
    intcon_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; int_in = 1'b0; ioc_in = 1'b0; tmr0_ovf = 1'b0;
    intcon_we = 1'b0; intcon_wdata = 8'h00; irq_ack = 1'b0; retfie = 1'b0;
    cycle(2);
    check("rst_intcon", {8'h0, intcon_q}, 16'h0000);
    check("rst_req", {15'h0, irq_req}, 16'h0);
    check("rst_strobes", {13'h0, push_pc, save_w, vec_load}, 16'h0);
    check("rst_src_isr", {13'h0, irq_src, in_isr}, 16'h0);
    rst = 1'b0;
    cycle(1);

    // INT edge with GIE and INTE enabled, full entry sequence
    wrIntcon(8'h90);
    check("t1_wr", {8'h0, intcon_q}, 16'h0090);
    int_in = 1'b1;
    cycle(1);
    check("t1_intf", {8'h0, intcon_q}, 16'h0092);
    check("t1_req_early", {15'h0, irq_req}, 16'h0);
    cycle(1);
    check("t1_req", {15'h0, irq_req}, 16'h1);
    irq_ack = 1'b1;
    cycle(1);
    irq_ack = 1'b0;
    check("t1_push", {13'h0, push_pc, save_w, vec_load}, 16'h4);
    check("t1_req_off", {15'h0, irq_req}, 16'h0);
    check("t1_src", {14'h0, irq_src}, 16'h1);
    check("t1_gie_clr", {8'h0, intcon_q}, 16'h0012);
    cycle(1);
    check("t1_save", {13'h0, push_pc, save_w, vec_load}, 16'h2);
    cycle(1);
    check("t1_vec", {13'h0, push_pc, save_w, vec_load}, 16'h1);
    check("t1_vaddr", {5'h0, vec_addr}, 16'h0004);
    cycle(1);
    check("t1_isr", {12'h0, push_pc, save_w, vec_load, in_isr}, 16'h1);

    // second INT edge inside the service routine
    int_in = 1'b0;
    cycle(1);
    wrIntcon(8'h10);
    check("t6_clr", {8'h0, intcon_q}, 16'h0010);
    int_in = 1'b1;
    cycle(1);
    check("t6_intf", {8'h0, intcon_q}, 16'h0012);
    cycle(2);
    check("t6_noreq", {15'h0, irq_req}, 16'h0);
    retfie = 1'b1;
    cycle(1);
    retfie = 1'b0;
    check("t6_retfie", {8'h0, intcon_q}, 16'h0092);
    check("t6_isr_off", {13'h0, irq_src, in_isr}, 16'h0);
    cycle(1);
    check("t6_rereq", {15'h0, irq_req}, 16'h1);
    wrIntcon(8'h00);
    cycle(1);
    check("t1_drop", {15'h0, irq_req}, 16'h0);
    int_in = 1'b0;

    // Timer0 flag with GIE off, then enable
    wrIntcon(8'h20);
    tmr0_ovf = 1'b1;
    cycle(1);
    tmr0_ovf = 1'b0;
    check("t2_tmr0if", {8'h0, intcon_q}, 16'h0024);
    cycle(2);
    check("t2_noreq", {15'h0, irq_req}, 16'h0);
    wrIntcon(8'hA4);
    cycle(1);
    check("t2_req", {15'h0, irq_req}, 16'h1);
    irq_ack = 1'b1;
    cycle(1);
    irq_ack = 1'b0;
    check("t2_src", {14'h0, irq_src}, 16'h2);
    check("t2_push", {15'h0, push_pc}, 16'h1);
    cycle(3);
    check("t2_isr", {15'h0, in_isr}, 16'h1);
    wrIntcon(8'h00);
    retfie = 1'b1;
    cycle(1);
    retfie = 1'b0;
    check("t2_retfie", {8'h0, intcon_q}, 16'h0080);
    cycle(2);
    check("t2_idle", {14'h0, irq_req, in_isr}, 16'h0);

    // RETFIE outside ISR only sets GIE
    wrIntcon(8'h00);
    retfie = 1'b1;
    cycle(1);
    retfie = 1'b0;
    check("t7_gie", {8'h0, intcon_q}, 16'h0080);
    check("t7_state", {14'h0, irq_req, in_isr}, 16'h0);
    wrIntcon(8'h00);

    // INT and IOC together: INT wins, IOC follows after RETFIE
    wrIntcon(8'h98);
    int_in = 1'b1;
    ioc_in = 1'b1;
    cycle(1);
    check("t3_flags", {8'h0, intcon_q}, 16'h009B);
    cycle(1);
    check("t3_req", {15'h0, irq_req}, 16'h1);
    irq_ack = 1'b1;
    cycle(1);
    irq_ack = 1'b0;
    check("t3_src_int", {14'h0, irq_src}, 16'h1);
    cycle(3);
    wrIntcon(8'h19);
    retfie = 1'b1;
    cycle(1);
    retfie = 1'b0;
    check("t3_retfie", {8'h0, intcon_q}, 16'h0099);
    cycle(1);
    check("t3_rereq", {15'h0, irq_req}, 16'h1);
    irq_ack = 1'b1;
    cycle(1);
    irq_ack = 1'b0;
    check("t3_src_ioc", {14'h0, irq_src}, 16'h3);
    cycle(1);
    check("t5_in_save", {15'h0, save_w}, 16'h1);

    // reset in SAVE aborts at once
    rst = 1'b1;
    #2;
    check("t5_intcon", {8'h0, intcon_q}, 16'h0000);
    check("t5_outs", {10'h0, irq_req, push_pc, save_w, vec_load, in_isr, 1'b0}, 16'h0);
    check("t5_src", {14'h0, irq_src}, 16'h0);
    int_in = 1'b0;
    ioc_in = 1'b0;
    cycle(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1);
      check("t5_novec", {13'h0, push_pc, save_w, vec_load}, 16'h0);
    end

    // core write and INT flag set in the same cycle
    intcon_we    = 1'b1;
    intcon_wdata = 8'h90;
    int_in       = 1'b1;
    cycle(1);
    intcon_we    = 1'b0;
    check("t4_merge", {8'h0, intcon_q}, 16'h0092);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller for the single-cycle PIC16F1826 core. It owns the INTCON register and edge-detects the INT pin, the IOC event and the Timer0 overflow. When an enabled interrupt is pending it hands the core an interrupt request. After the core acknowledges, it sequences interrupt entry: clear GIE, push the PC, save W, load the vector. It sits between the Timer0/pin sources and the Cpu controller FSM, replacing the ad-hoc INTCON logic there.

## Interface
- `PC_W`, 11: program-counter width.
- `VECTOR`, 11'h004: interrupt vector address.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `int_in`  in  1  external INT pin, level.
- `ioc_in`  in  1  interrupt-on-change event, level.
- `tmr0_ovf`  in  1  Timer0 overflow flag, level.
- `intcon_we`  in  1  core write strobe for INTCON (addr 0x0B).
- `intcon_wdata`  in  8  core write data.
- `intcon_q`  out  8  INTCON: GIE, PEIE, TMR0IE, INTE, IOCIE, TMR0IF, INTF, IOCIF (bit 7 to bit 0).
- `irq_req`  out  1  request to core; registered.
- `irq_ack`  in  1  core accepts the request at an instruction boundary (its fetch state).
- `retfie`  in  1  one-cycle pulse when the core executes RETFIE.
- `push_pc`  out  1  one-cycle stack push strobe.
- `save_w`  out  1  one-cycle strobe to write W to the shadow location.
- `vec_load`  out  1  one-cycle PC load strobe.
- `vec_addr`  out  PC_W  always VECTOR.
- `irq_src`  out  2  cause of the accepted interrupt: 0 none, 1 INT, 2 TMR0, 3 IOC.
- `in_isr`  out  1  high while the service routine runs.

## Operation
- Each source has its own rising-edge detector (a previous-value register). A detected edge sets the matching IF bit on the next clock edge, whatever GIE is.
- A core write loads all 8 bits of INTCON.
- If a hardware set and a core write hit the same IF bit in the same cycle, the hardware set wins: the bit ends as `wdata | set`.
- `pend = |({TMR0IE, INTE, IOCIE} & {TMR0IF, INTF, IOCIF})`. PEIE is stored but has no source yet.
- FSM states:
  - IDLE: go to REQ when `GIE & pend`.
  - REQ: `irq_req` = 1.
    - On `irq_ack`: clear GIE, latch `irq_src`, go to PUSH.
    - If `GIE` or `pend` drops before ack: return to IDLE and deassert `irq_req`.
  - PUSH: `push_pc` = 1, go to SAVE.
  - SAVE: `save_w` = 1, go to VEC.
  - VEC: `vec_load` = 1, go to ISR.
  - ISR: `in_isr` = 1. New edges still set IF bits; no request is raised.
    - On `retfie`: set GIE, clear `irq_src`, go to IDLE.
- IF bits are never cleared by hardware; software clears them by writing INTCON.
- `irq_src` priority when several sources are pending: INT > TMR0 > IOC.
- `retfie` outside ISR only sets GIE; the state does not change.
- `irq_ack` outside REQ is ignored.

## Timing
- Reset (asynchronous): INTCON = 0, FSM = IDLE, all strobes = 0, `irq_src` = 0, edge-detect registers = 0.
- Edge seen at edge N: IF set at edge N+1 → REQ at N+2 → `irq_req` high from N+2.
- Ack at edge A: `push_pc` high for cycle A+1, `save_w` for A+2, `vec_load` for A+3, `in_isr` from A+4.
- Each strobe is high for exactly one cycle.
- After `retfie` with an enabled flag still set: back in REQ two edges later.
- Reset asserted mid-sequence aborts immediately. No strobe may glitch high after reset deasserts.

## Configuration
- `INT_SYNC_EN` defined: `int_in` and `ioc_in` each pass through a 2-flop synchronizer before edge detection. IF set latency becomes 3 edges.
- `INT_SYNC_EN` undefined: the inputs feed the edge detectors directly, with the latency given above.
- `tmr0_ovf` is never synchronized.

## Structure
- Shared package `pic_pkg`:
  - INTCON bit-index constants.
  - FSM state enum (IDLE, REQ, PUSH, SAVE, VEC, ISR).
  - `irq_src` encodings.
  - INTCON and shadow-W addresses (0x0B, 0x09).
- One sub-module, `edge_det`: the optional synchronizer plus rising-edge detector, instantiated three times.

## Test plan
- GIE = 1, INTE = 1, `int_in` 0→1 → INTF = 1 after 1 edge; `irq_req` after 2.
  - Ack → `push_pc`, `save_w`, `vec_load` on consecutive cycles.
  - `vec_addr` = 0x004, `irq_src` = 1, GIE = 0.
- GIE = 0, TMR0IE = 1, `tmr0_ovf` pulses → TMR0IF = 1, no `irq_req`. Write INTCON = 0xA4 → `irq_req` 2 edges later, `irq_src` = 2 on ack.
- INT and IOC edges in the same cycle, both enabled → `irq_src` = 1. After the RETFIE pulse with IOCIF still set → `irq_req` again; ack gives `irq_src` = 3.
- Core writes INTCON = 0x90 in the same cycle as an INT edge's flag set → `intcon_q` = 0x92.
- `rst` asserted during SAVE → all outputs 0 at once, INTCON = 0x00, no `vec_load` afterwards.
- In ISR, a second INT edge → INTF set, `irq_req` stays 0 until `retfie`.
